// File: rtl/ex_btc_enc_cell_if.sv
// rtl/ex_btc_enc_cell_if.sv - pixel-in / cell-out handshake bundle for ex_btc_enc_cell
// out_flat exists only when JX2_ENCCC_FLATCELL_EN is defined.
interface ex_btc_enc_cell_if #(
  parameter int CELL_PIX     = 16,
  parameter int PIX_PER_BEAT = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [16*PIX_PER_BEAT-1:0] in_pix;
  logic                       out_valid;
  logic                       out_ready;
  logic [32+2*CELL_PIX-1:0]   out_cell;
`ifdef JX2_ENCCC_FLATCELL_EN
  logic                       out_flat;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_cell, out_flat
  );
  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_cell, out_flat
  );
`else
  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_cell
  );
  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_cell
  );
`endif
endinterface

// File: rtl/ex_btc_enc_cell.sv
// rtl/ex_btc_enc_cell.sv - streaming RGB555 BTC cell encoder (luma endpoints + 2-bit indices)
// Optional flat-cell bypass and out_flat port enabled by JX2_ENCCC_FLATCELL_EN.
module ex_btc_enc_cell #(
  parameter int CELL_PIX     = 16,
  parameter int PIX_PER_BEAT = 4,
  parameter int IDX_ORDER    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  ex_btc_enc_cell_if.slave bus
);
  localparam int NBEAT = CELL_PIX / PIX_PER_BEAT;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int IW    = 2 * CELL_PIX;
  localparam int GW    = 2 * PIX_PER_BEAT;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_THRESH = 2'd1;
  localparam logic [1:0] ST_CLASS  = 2'd2;
  localparam logic [1:0] ST_EMIT   = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(NBEAT - 1);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [14:0]     pix_buf [CELL_PIX];
  logic [14:0]     min_pix, max_pix;
  logic [7:0]      min_y, max_y;
  logic [7:0]      y_hi, y_lo, y_mi;
  logic [IW-1:0]   idx;
  logic [IW+31:0]  cell_q;
`ifdef JX2_ENCCC_FLATCELL_EN
  logic            flat_q;
`endif

  function automatic logic [7:0] luma(input logic [14:0] p);
    return {p[9], p[8], p[14], p[4], p[7], p[13], p[3], p[6]};
  endfunction

  // Running endpoints across one beat; strict compares keep the earliest pixel on ties.
  logic [14:0] bmin_pix, bmax_pix, cur_pix;
  logic [7:0]  bmin_y, bmax_y, cur_y;
  always_comb begin
    bmin_pix = min_pix;
    bmax_pix = max_pix;
    bmin_y   = min_y;
    bmax_y   = max_y;
    cur_pix  = '0;
    cur_y    = '0;
    for (int j = 0; j < PIX_PER_BEAT; j++) begin
      cur_pix = bus.in_pix[16*j +: 15];
      cur_y   = luma(cur_pix);
      if (cnt == '0 && j == 0) begin
        bmin_pix = cur_pix;
        bmax_pix = cur_pix;
        bmin_y   = cur_y;
        bmax_y   = cur_y;
      end else begin
        if (cur_y < bmin_y) begin
          bmin_pix = cur_pix;
          bmin_y   = cur_y;
        end
        if (cur_y > bmax_y) begin
          bmax_pix = cur_pix;
          bmax_y   = cur_y;
        end
      end
    end
  end

  logic [14:0] th_hi, th_lo, th_mi;
  logic [4:0]  mn, mx;
  always_comb begin
    th_hi = '0;
    th_lo = '0;
    th_mi = '0;
    mn    = '0;
    mx    = '0;
    for (int c = 0; c < 3; c++) begin
      mn = min_pix[5*c +: 5];
      mx = max_pix[5*c +: 5];
      th_mi[5*c +: 5] = (mn >> 1) + (mx >> 1);
      th_hi[5*c +: 5] = (mx >> 1) + (mn >> 2) + (mx >> 3) + (mn >> 3);
      th_lo[5*c +: 5] = (mn >> 1) + (mx >> 2) + (mn >> 3) + (mx >> 3);
    end
  end

  // pix_buf[0 +: PIX_PER_BEAT] always holds the next group to classify; codes shift into idx.
  logic [GW-1:0] codes;
  logic [1:0]    code;
  logic [7:0]    py;
  logic [IW-1:0] idx_next;
  always_comb begin
    codes    = '0;
    code     = '0;
    py       = '0;
    idx_next = idx;
    for (int j = 0; j < PIX_PER_BEAT; j++) begin
      py = luma(pix_buf[j]);
      if (py > y_mi) code = (py > y_hi) ? 2'd3 : 2'd2;
      else           code = (py > y_lo) ? 2'd1 : 2'd0;
      if (IDX_ORDER == 0) codes[2*j +: 2] = code;
      else                codes[2*(PIX_PER_BEAT-1-j) +: 2] = code;
    end
    if (IDX_ORDER == 0) idx_next = {codes, idx[IW-1:GW]};
    else                idx_next = {idx[IW-GW-1:0], codes};
  end

  always_ff @(posedge clock) begin
    if (!hold && ((state == ST_LOAD && bus.in_valid) || state == ST_CLASS)) begin
      for (int i = 0; i < CELL_PIX - PIX_PER_BEAT; i++)
        pix_buf[i] <= pix_buf[i + PIX_PER_BEAT];
      for (int j = 0; j < PIX_PER_BEAT; j++)
        pix_buf[CELL_PIX - PIX_PER_BEAT + j] <= bus.in_pix[16*j +: 15];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_LOAD;
      cnt     <= '0;
      min_pix <= '0;
      max_pix <= '0;
      min_y   <= '0;
      max_y   <= '0;
      y_hi    <= '0;
      y_lo    <= '0;
      y_mi    <= '0;
      idx     <= '0;
      cell_q  <= '0;
`ifdef JX2_ENCCC_FLATCELL_EN
      flat_q  <= 1'b0;
`endif
    end else if (!hold) begin
      case (state)
        ST_LOAD: begin
          if (bus.in_valid) begin
            min_pix <= bmin_pix;
            max_pix <= bmax_pix;
            min_y   <= bmin_y;
            max_y   <= bmax_y;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_THRESH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_THRESH: begin
          y_hi <= luma(th_hi);
          y_lo <= luma(th_lo);
          y_mi <= luma(th_mi);
          cnt  <= '0;
`ifdef JX2_ENCCC_FLATCELL_EN
          if (min_y == max_y) begin
            cell_q <= {1'b0, min_pix, 1'b0, max_pix, {IW{1'b0}}};
            flat_q <= 1'b1;
            state  <= ST_EMIT;
          end else begin
            flat_q <= 1'b0;
            state  <= ST_CLASS;
          end
`else
          state <= ST_CLASS;
`endif
        end
        ST_CLASS: begin
          idx <= idx_next;
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            cell_q <= {1'b0, min_pix, 1'b0, max_pix, idx_next};
            state  <= ST_EMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) state <= ST_LOAD;
        end
      endcase
    end
  end

  logic unused_msb;
  always_comb begin
    unused_msb = 1'b0;
    for (int j = 0; j < PIX_PER_BEAT; j++)
      unused_msb = unused_msb ^ bus.in_pix[16*j+15];
  end

  assign bus.in_ready  = (state == ST_LOAD) && !hold;
  assign bus.out_valid = (state == ST_EMIT);
  assign bus.out_cell  = cell_q;
`ifdef JX2_ENCCC_FLATCELL_EN
  assign bus.out_flat  = flat_q;
`endif

endmodule

// File: tb/tb_ex_btc_enc_cell.sv
// tb/tb_ex_btc_enc_cell.sv - randomized self-checking bench for ex_btc_enc_cell
// dut0: 16 pix, 4 pix/beat, IDX_ORDER 0; dut1: 16 pix, 1 pix/beat, IDX_ORDER 1.
module tb_ex_btc_enc_cell;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic hold  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  ex_btc_enc_cell_if #(.CELL_PIX(16), .PIX_PER_BEAT(4)) bus0 ();
  ex_btc_enc_cell_if #(.CELL_PIX(16), .PIX_PER_BEAT(1)) bus1 ();

  ex_btc_enc_cell #(.CELL_PIX(16), .PIX_PER_BEAT(4), .IDX_ORDER(0)) dut0 (
    .clock(clock), .reset(reset), .hold(hold), .bus(bus0));
  ex_btc_enc_cell #(.CELL_PIX(16), .PIX_PER_BEAT(1), .IDX_ORDER(1)) dut1 (
    .clock(clock), .reset(reset), .hold(hold), .bus(bus1));

  int   cyc = 0;
  int   rise_q[$];
  logic ov_prev = 1'b0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (bus0.out_valid && !ov_prev) rise_q.push_back(cyc);
    ov_prev = bus0.out_valid;
  end

  logic [15:0] px [16];
  logic [63:0] exp_cell;
  bit          exp_flat;

  function automatic logic [7:0] yof(input logic [15:0] p);
    return {p[9], p[8], p[14], p[4], p[7], p[13], p[3], p[6]};
  endfunction

  // Reference: first-occurrence luma extremes, per-channel threshold arithmetic, direct index placement.
  task automatic model(input int order);
    int lo_i, hi_i, a, b, t_hi, t_lo, t_mi, yv, pos;
    logic [15:0] mn, mx;
    logic [31:0] ix;
    logic [1:0]  code;
    lo_i = 0; hi_i = 0;
    for (int k = 1; k < 16; k++) begin
      if (yof(px[k]) < yof(px[lo_i])) lo_i = k;
      if (yof(px[k]) > yof(px[hi_i])) hi_i = k;
    end
    mn = px[lo_i] & 16'h7FFF;
    mx = px[hi_i] & 16'h7FFF;
    t_hi = 0; t_lo = 0; t_mi = 0;
    for (int c = 0; c < 3; c++) begin
      a = (mn >> (5*c)) & 31;
      b = (mx >> (5*c)) & 31;
      t_mi += (a/2 + b/2) << (5*c);
      t_hi += (b/2 + a/4 + b/8 + a/8) << (5*c);
      t_lo += (a/2 + b/4 + a/8 + b/8) << (5*c);
    end
    exp_flat = 1'b0;
`ifdef JX2_ENCCC_FLATCELL_EN
    exp_flat = (yof(mn) == yof(mx));
`endif
    ix = '0;
    for (int k = 0; k < 16; k++) begin
      yv = yof(px[k]);
      if (yv > yof(16'(t_mi))) code = (yv > yof(16'(t_hi))) ? 2'd3 : 2'd2;
      else                     code = (yv > yof(16'(t_lo))) ? 2'd1 : 2'd0;
      pos = (order != 0) ? 15 - k : k;
      if (!exp_flat) ix[2*pos +: 2] = code;
    end
    exp_cell = {mn, mx, ix};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic ov(input int d);
    return (d != 0) ? bus1.out_valid : bus0.out_valid;
  endfunction
  function automatic logic ir(input int d);
    return (d != 0) ? bus1.in_ready : bus0.in_ready;
  endfunction
  function automatic logic [63:0] oc(input int d);
    return (d != 0) ? bus1.out_cell : bus0.out_cell;
  endfunction

  task automatic feed(input int d, input int nbeats);
    int g;
    for (int b = 0; b < nbeats; b++) begin
      if (d == 0) begin
        bus0.in_valid = 1'b1;
        for (int j = 0; j < 4; j++) bus0.in_pix[16*j +: 16] = px[4*b+j];
      end else begin
        bus1.in_valid = 1'b1;
        bus1.in_pix   = px[b];
      end
      g = 0;
      while (!ir(d) && g < 200) begin step(); g++; end
      if (!ir(d)) begin
        total++; bad++;
        $display("FAIL feed_timeout dut%0d beat %0d: in_ready=0 required 1", d, b);
      end
      step();
    end
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int d, output int lat);
    int e;
    e = 0;
    while (!ov(d) && e < 200) begin step(); e++; end
    lat = e + 1;
  endtask

  task automatic consume(input int d);
    if (d == 0) bus0.out_ready = 1'b1; else bus1.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready); end
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid); end
    total++; if (bus0.out_cell !== 64'h0) begin bad++; $display("FAIL reset_out_cell: got %h want 0", bus0.out_cell); end
    total++; if (bus1.out_cell !== 64'h0 || bus1.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dut1: got valid=%b cell=%h want 0/0", bus1.out_valid, bus1.out_cell); end
`ifdef JX2_ENCCC_FLATCELL_EN
    total++; if (bus0.out_flat !== 1'b0) begin bad++; $display("FAIL reset_out_flat: got %b want 0", bus0.out_flat); end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_pattern();
    int lat;
    for (int k = 0; k < 16; k++) px[k] = k[0] ? 16'h7FFF : 16'h0000;
    feed(0, 4);
    wait_out(0, lat);
    total++; if (lat != 6) begin bad++; $display("FAIL pattern_latency: got %0d want 6", lat); end
    total++; if (bus0.out_cell !== 64'h00007FFF_CCCCCCCC) begin
      bad++; $display("FAIL pattern_cell: got %h want 00007fffcccccccc", bus0.out_cell); end
`ifdef JX2_ENCCC_FLATCELL_EN
    total++; if (bus0.out_flat !== 1'b0) begin bad++; $display("FAIL pattern_flat: got %b want 0", bus0.out_flat); end
`endif
    consume(0);
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL pattern_release: got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_idx_order();
    int lat;
    for (int k = 0; k < 16; k++) px[k] = k[0] ? 16'h7FFF : 16'h0000;
    feed(1, 16);
    wait_out(1, lat);
    total++; if (lat != 18) begin bad++; $display("FAIL order_latency: got %0d want 18", lat); end
    total++; if (bus1.out_cell !== 64'h00007FFF_33333333) begin
      bad++; $display("FAIL order_cell: got %h want 00007fff33333333", bus1.out_cell); end
    consume(1);
  endtask

  task automatic test_tie();
    int lat;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 16; k++) px[k] = 16'h0000;
      case (t)
        0: begin px[2] = 16'h7FFF; px[9] = 16'h7FFF; end
        1: begin px[2] = 16'h7FFF; px[9] = 16'h7FFE; end
        default: begin px[0] = 16'h0001; px[2] = 16'h7FFE; px[9] = 16'h7FFF; end
      endcase
      model(0);
      feed(0, 4);
      wait_out(0, lat);
      if (t == 0) begin
        total++; if (bus0.out_cell[63:32] !== 32'h00007FFF) begin
          bad++; $display("FAIL tie_spec_endpoints: got %h want 00007fff", bus0.out_cell[63:32]); end
      end else if (t == 2) begin
        total++; if (bus0.out_cell[63:32] !== 32'h00017FFE) begin
          bad++; $display("FAIL tie_first_endpoints: got %h want 00017ffe", bus0.out_cell[63:32]); end
      end
      total++; if (bus0.out_cell !== exp_cell) begin
        bad++; $display("FAIL tie_cell_%0d: got %h want %h", t, bus0.out_cell, exp_cell); end
      consume(0);
    end
  endtask

  task automatic test_hold();
    int e;
    logic [63:0] held;
    for (int k = 0; k < 16; k++) px[k] = 16'($urandom);
    px[0] = 16'h0000;
    px[1] = 16'h7FFF;
    model(0);
    feed(0, 4);
    step();
    hold = 1'b1;
    repeat (3) step();
    hold = 1'b0;
    e = 4;
    while (!bus0.out_valid && e < 200) begin step(); e++; end
    total++; if (e + 1 != 9) begin bad++; $display("FAIL hold_latency: got %0d want 9", e + 1); end
    total++; if (bus0.out_cell !== exp_cell) begin
      bad++; $display("FAIL hold_cell: got %h want %h", bus0.out_cell, exp_cell); end
    held = exp_cell;
    bus0.out_ready = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus0.out_valid !== 1'b1 || bus0.out_cell !== held || bus0.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_emit_%0d: got valid=%b ready=%b cell=%h want 1/0/%h",
                        i, bus0.out_valid, bus0.in_ready, bus0.out_cell, held); end
    end
    hold = 1'b0;
    step();
    bus0.out_ready = 1'b0;
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int k = 0; k < 16; k++) px[k] = 16'($urandom);
    feed(0, 2);
    reset = 1'b0;
    #2;
    total++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_state: got ready=%b valid=%b want 1/0", bus0.in_ready, bus0.out_valid); end
    step();
    reset = 1'b1;
    for (int k = 0; k < 16; k++) px[k] = 16'($urandom);
    model(0);
    feed(0, 4);
    wait_out(0, lat);
    total++; if (lat != (exp_flat ? 2 : 6)) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, exp_flat ? 2 : 6); end
    total++; if (bus0.out_cell !== exp_cell) begin
      bad++; $display("FAIL midreset_cell: got %h want %h", bus0.out_cell, exp_cell); end
    consume(0);
  endtask

  task automatic test_flat();
    int lat;
    for (int k = 0; k < 16; k++) px[k] = 16'h1234;
    model(0);
    feed(0, 4);
    wait_out(0, lat);
`ifdef JX2_ENCCC_FLATCELL_EN
    total++; if (lat != 2) begin bad++; $display("FAIL flat_latency: got %0d want 2", lat); end
    total++; if (bus0.out_cell !== 64'h12341234_00000000) begin
      bad++; $display("FAIL flat_cell: got %h want 1234123400000000", bus0.out_cell); end
    total++; if (bus0.out_flat !== 1'b1) begin bad++; $display("FAIL flat_flag: got %b want 1", bus0.out_flat); end
`else
    total++; if (lat != 6) begin bad++; $display("FAIL flat_latency: got %0d want 6", lat); end
    total++; if (bus0.out_cell !== exp_cell) begin
      bad++; $display("FAIL flat_cell: got %h want %h", bus0.out_cell, exp_cell); end
`endif
    consume(0);
  endtask

  task automatic test_back_to_back();
    int lat;
    rise_q.delete();
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 16; k++) px[k] = 16'($urandom);
      px[0] = 16'h0000;
      px[1] = 16'h7FFF;
      model(0);
      feed(0, 4);
    end
    wait_out(0, lat);
    total++; if (bus0.out_cell !== exp_cell) begin
      bad++; $display("FAIL b2b_cell: got %h want %h", bus0.out_cell, exp_cell); end
    step();
    bus0.out_ready = 1'b0;
    total++; if (rise_q.size() != 2 || rise_q[1] - rise_q[0] != 10) begin
      bad++; $display("FAIL b2b_period: got %0d rises gap %0d want 2 rises gap 10",
                      rise_q.size(), (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1); end
  endtask

  task automatic test_random();
    int lat, d, nb, r;
    logic [15:0] pool [4];
    for (int it = 0; it < 24; it++) begin
      d  = (it % 6 == 5) ? 1 : 0;
      nb = (d != 0) ? 16 : 4;
      for (int p = 0; p < 4; p++) pool[p] = 16'($urandom);
      for (int k = 0; k < 16; k++)
        px[k] = it[0] ? pool[$urandom_range(0, 3)] : 16'($urandom);
      if (it == 7) for (int k = 0; k < 16; k++) px[k] = pool[0] ^ (16'($urandom) & 16'h1C27);
      model(d);
      feed(d, nb);
      wait_out(d, lat);
      total++; if (lat != (exp_flat ? 2 : nb + 2)) begin
        bad++; $display("FAIL rand_latency_%0d: got %0d want %0d", it, lat, exp_flat ? 2 : nb + 2); end
      total++; if (oc(d) !== exp_cell) begin
        bad++; $display("FAIL rand_cell_%0d: got %h want %h", it, oc(d), exp_cell); end
`ifdef JX2_ENCCC_FLATCELL_EN
      total++; if (((d != 0) ? bus1.out_flat : bus0.out_flat) !== exp_flat) begin
        bad++; $display("FAIL rand_flat_%0d: got %b want %b", it, (d != 0) ? bus1.out_flat : bus0.out_flat, exp_flat); end
`endif
      r = $urandom_range(1, 3);
      repeat (r) step();
      total++; if (ov(d) !== 1'b1 || oc(d) !== exp_cell) begin
        bad++; $display("FAIL rand_stall_%0d: got valid=%b cell=%h want 1/%h", it, ov(d), oc(d), exp_cell); end
      consume(d);
      total++; if (ov(d) !== 1'b0) begin bad++; $display("FAIL rand_release_%0d: got %b want 0", it, ov(d)); end
    end
  endtask

  initial begin
    bus0.in_valid = 1'b0; bus0.in_pix = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_pix = '0; bus1.out_ready = 1'b0;
    test_reset();
    test_pattern();
    test_idx_order();
    test_tie();
    test_hold();
    test_reset_mid();
    test_flat();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
